// File: rtl/uart_boot_loader.sv
// uart_boot_loader: packs UART bytes into words, writes them to instruction memory, then releases the core
// Defining BOOT_LOADER_CHECKSUM_EN adds a trailing checksum word that is checked after the terminator.
module uart_boot_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              write_done,
  output logic              cpu_resetn,
  output logic [1:0]        err_code
);
  localparam int nb = DATA_W / 8;
  localparam int bw = nb > 1 ? $clog2(nb) : 1;
  localparam int tw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int cw = ADDR_W + 1;
  localparam int nb_m1 = nb - 1;
  localparam logic [bw-1:0] last_idx = nb_m1[bw-1:0];
  localparam logic [tw-1:0] tmo = TIMEOUT_CYCLES[tw-1:0];
  localparam logic [ADDR_W:0] full_cnt = DEPTH[ADDR_W:0];
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CHECK = 2'd3,
`endif
    ERROR = 2'd2
  } state_t;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t term_next = CHECK;
`else
  localparam state_t term_next = DONE;
`endif
  state_t state, next_state;
  logic [bw-1:0] byte_idx;
  logic [DATA_W-1:0] word_buf, word_next;
  logic [tw-1:0] idle;
  logic [1:0] err_next;
  logic rx_state, accept, word_done, expire, is_term, full, do_write;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  assign rx_state = state == LOAD || state == CHECK;
`else
  assign rx_state = state == LOAD;
`endif
  assign accept = rx_valid && !rx_break && rx_state;
  assign word_done = accept && byte_idx == last_idx;
  assign expire = !rx_valid && byte_idx != '0 && idle == tmo;
  assign is_term = word_next == {DATA_W{1'b1}};
  assign full = word_count == full_cnt;
  assign do_write = word_done && state == LOAD && !is_term && !full;
  always_comb begin
    word_next = word_buf;
    word_next[{byte_idx, 3'b000} +: 8] = rx_data;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= LOAD;
    else state <= next_state;
  always_comb begin
    next_state = state;
    if (rx_break) next_state = LOAD;
    else if (word_done && state == LOAD) next_state = is_term ? term_next : full ? ERROR : LOAD;
`ifdef BOOT_LOADER_CHECKSUM_EN
    else if (word_done && state == CHECK) next_state = word_next == sum ? DONE : ERROR;
`endif
  end
  always_comb begin
    err_next = rx_break ? 2'd0 : word_done && state == LOAD && !is_term && full ? 2'd1 : err_code;
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (!rx_break && word_done && state == CHECK && word_next != sum) err_next = 2'd2;
`endif
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      word_count <= '0;
      write_done <= 1'b0;
      cpu_resetn <= 1'b0;
      err_code <= 2'd0;
    end else begin
      mem_we <= do_write;
      write_done <= next_state == DONE;
      cpu_resetn <= next_state == DONE;
      err_code <= err_next;
      word_count <= rx_break ? '0 : do_write ? word_count + cw'(1) : word_count;
      if (do_write) begin
        mem_addr <= word_count[ADDR_W-1:0];
        mem_wdata <= word_next;
      end
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      byte_idx <= '0;
      word_buf <= '0;
      idle <= '0;
    end else begin
      byte_idx <= rx_break || expire ? '0 : accept ? (byte_idx == last_idx ? '0 : byte_idx + bw'(1)) : byte_idx;
      word_buf <= accept ? word_next : word_buf;
      idle <= rx_break || rx_valid || expire || byte_idx == '0 ? '0 : idle + tw'(1);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sum <= '0;
    else sum <= rx_break ? '0 : do_write ? sum + word_next : sum;
`endif
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed checks of load, timeout, overflow, reload, break priority and optional checksum
module tb_uart_boot_loader;
  localparam int DW = 32;
  localparam int DEP = 4;
  localparam int AW = 2;
  localparam int TMO = 40;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_break = 1'b0;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0] word_count;
  logic write_done, cpu_resetn;
  logic [1:0] err_code;
  int compared = 0;
  int mismatched = 0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  uart_boot_loader #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_count(word_count),
    .write_done(write_done), .cpu_resetn(cpu_resetn), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW / 8; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    rx_break = 1'b1;
    @(negedge clk);
    rx_break = 1'b0;
    idle(1);
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    #4000;
    compared += 5;
    if (mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    if (write_done !== 1'b0) begin mismatched++; $display("FAIL reset_write_done: got %b want 0", write_done); end
    if (cpu_resetn !== 1'b0) begin mismatched++; $display("FAIL reset_cpu_resetn: got %b want 0", cpu_resetn); end
    if (err_code !== 2'd0) begin mismatched++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    if (word_count !== '0) begin mismatched++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    @(negedge clk);
    resetn = 1'b1;
    idle(2);
  endtask

  task automatic test_load();
    send_word(32'h00500013);
    send_word(32'hFFFFFFFF);
    idle(2);
    compared += 4;
    if (log_addr.size() !== 1) begin mismatched++; $display("FAIL load_writes: got %0d want 1", log_addr.size()); end
    else begin
      compared += 2;
      if (log_addr[0] !== 2'd0) begin mismatched++; $display("FAIL load_addr: got %0d want 0", log_addr[0]); end
      if (log_data[0] !== 32'h00500013) begin mismatched++; $display("FAIL load_data: got %h want 00500013", log_data[0]); end
    end
    if (write_done !== 1'b1) begin mismatched++; $display("FAIL load_write_done: got %b want 1", write_done); end
    if (cpu_resetn !== 1'b1) begin mismatched++; $display("FAIL load_cpu_resetn: got %b want 1", cpu_resetn); end
    if (word_count !== 3'd1) begin mismatched++; $display("FAIL load_word_count: got %0d want 1", word_count); end
    send_word(32'h12345678);
    idle(2);
    compared += 3;
    if (log_addr.size() !== 1) begin mismatched++; $display("FAIL done_ignore_writes: got %0d want 1", log_addr.size()); end
    if (word_count !== 3'd1) begin mismatched++; $display("FAIL done_ignore_count: got %0d want 1", word_count); end
    if (write_done !== 1'b1) begin mismatched++; $display("FAIL done_ignore_done: got %b want 1", write_done); end
  endtask

  task automatic test_reload();
    restart();
    compared += 4;
    if (write_done !== 1'b0) begin mismatched++; $display("FAIL reload_write_done: got %b want 0", write_done); end
    if (cpu_resetn !== 1'b0) begin mismatched++; $display("FAIL reload_cpu_resetn: got %b want 0", cpu_resetn); end
    if (word_count !== '0) begin mismatched++; $display("FAIL reload_word_count: got %0d want 0", word_count); end
    if (err_code !== 2'd0) begin mismatched++; $display("FAIL reload_err_code: got %0d want 0", err_code); end
    send_word(32'hDEADBEEF);
    idle(2);
    compared += 2;
    if (log_addr.size() !== 1) begin mismatched++; $display("FAIL reload_writes: got %0d want 1", log_addr.size()); end
    else begin
      compared += 2;
      if (log_addr[0] !== 2'd0) begin mismatched++; $display("FAIL reload_addr: got %0d want 0", log_addr[0]); end
      if (log_data[0] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL reload_data: got %h want deadbeef", log_data[0]); end
    end
    if (word_count !== 3'd1) begin mismatched++; $display("FAIL reload_count: got %0d want 1", word_count); end
  endtask

  task automatic test_break_priority();
    restart();
    rx_break = 1'b1;
    send_byte(8'hAA);
    rx_break = 1'b0;
    send_word(32'h44332211);
    idle(2);
    compared += 1;
    if (log_data.size() !== 1) begin mismatched++; $display("FAIL brk_writes: got %0d want 1", log_data.size()); end
    else begin
      compared += 1;
      if (log_data[0] !== 32'h44332211) begin mismatched++; $display("FAIL brk_data: got %h want 44332211", log_data[0]); end
    end
  endtask

  task automatic test_timeout();
    restart();
    send_byte(8'h23);
    send_byte(8'h26);
    idle(TMO + 1);
    send_word(32'h00500013);
    idle(2);
    compared += 2;
    if (log_addr.size() !== 1) begin mismatched++; $display("FAIL tmo_writes: got %0d want 1", log_addr.size()); end
    else begin
      compared += 2;
      if (log_addr[0] !== 2'd0) begin mismatched++; $display("FAIL tmo_addr: got %0d want 0", log_addr[0]); end
      if (log_data[0] !== 32'h00500013) begin mismatched++; $display("FAIL tmo_data: got %h want 00500013", log_data[0]); end
    end
    if (err_code !== 2'd0) begin mismatched++; $display("FAIL tmo_err_code: got %0d want 0", err_code); end
    send_byte(8'h01);
    send_byte(8'h02);
    idle(TMO - 1);
    send_byte(8'h03);
    send_byte(8'h04);
    idle(2);
    compared += 1;
    if (log_data.size() !== 2) begin mismatched++; $display("FAIL tmo_edge_writes: got %0d want 2", log_data.size()); end
    else begin
      compared += 2;
      if (log_addr[1] !== 2'd1) begin mismatched++; $display("FAIL tmo_edge_addr: got %0d want 1", log_addr[1]); end
      if (log_data[1] !== 32'h04030201) begin mismatched++; $display("FAIL tmo_edge_data: got %h want 04030201", log_data[1]); end
    end
  endtask

  task automatic test_overflow();
    restart();
    for (int i = 1; i <= 5; i++) send_word(DW'(i));
    idle(2);
    compared += 5;
    if (log_addr.size() !== 4) begin mismatched++; $display("FAIL ovf_writes: got %0d want 4", log_addr.size()); end
    else
      for (int i = 0; i < 4; i++) begin
        compared += 2;
        if (log_addr[i] !== AW'(i)) begin mismatched++; $display("FAIL ovf_addr%0d: got %0d want %0d", i, log_addr[i], i); end
        if (log_data[i] !== DW'(i + 1)) begin mismatched++; $display("FAIL ovf_data%0d: got %h want %h", i, log_data[i], i + 1); end
      end
    if (err_code !== 2'd1) begin mismatched++; $display("FAIL ovf_err_code: got %0d want 1", err_code); end
    if (cpu_resetn !== 1'b0) begin mismatched++; $display("FAIL ovf_cpu_resetn: got %b want 0", cpu_resetn); end
    if (write_done !== 1'b0) begin mismatched++; $display("FAIL ovf_write_done: got %b want 0", write_done); end
    if (word_count !== 3'd4) begin mismatched++; $display("FAIL ovf_word_count: got %0d want 4", word_count); end
    send_word(32'hFFFFFFFF);
    idle(2);
    compared += 3;
    if (err_code !== 2'd1) begin mismatched++; $display("FAIL err_sticky: got %0d want 1", err_code); end
    if (write_done !== 1'b0) begin mismatched++; $display("FAIL err_ignore_done: got %b want 0", write_done); end
    if (log_addr.size() !== 4) begin mismatched++; $display("FAIL err_ignore_writes: got %0d want 4", log_addr.size()); end
  endtask

  task automatic test_checksum();
    restart();
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'hFFFFFFFF);
`ifdef BOOT_LOADER_CHECKSUM_EN
    compared += 1;
    if (write_done !== 1'b0) begin mismatched++; $display("FAIL cks_wait: got %b want 0", write_done); end
    send_word(32'h3);
`endif
    idle(2);
    compared += 3;
    if (write_done !== 1'b1) begin mismatched++; $display("FAIL cks_ok_done: got %b want 1", write_done); end
    if (cpu_resetn !== 1'b1) begin mismatched++; $display("FAIL cks_ok_cpu: got %b want 1", cpu_resetn); end
    if (err_code !== 2'd0) begin mismatched++; $display("FAIL cks_ok_err: got %0d want 0", err_code); end
`ifdef BOOT_LOADER_CHECKSUM_EN
    restart();
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'hFFFFFFFF);
    send_word(32'h4);
    idle(2);
    compared += 3;
    if (err_code !== 2'd2) begin mismatched++; $display("FAIL cks_bad_err: got %0d want 2", err_code); end
    if (write_done !== 1'b0) begin mismatched++; $display("FAIL cks_bad_done: got %b want 0", write_done); end
    if (cpu_resetn !== 1'b0) begin mismatched++; $display("FAIL cks_bad_cpu: got %b want 0", cpu_resetn); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_reload();
    test_break_priority();
    test_timeout();
    test_overflow();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
